// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the level word of a fixed-period PWM stream by counting
// high samples over each free-running 2^WIDTH-clock window.
module pwm_decoder #(
   parameter int WIDTH       = 8,
   parameter bit INVERT      = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] level,
   output logic             valid,
   output logic             full,
   output logic             stable
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [WIDTH-1:0]       r_win;
   logic [WIDTH:0]         r_cnt;
   logic [WIDTH:0]         r_prev;
   logic                   r_done;
   logic                   w_sample;
   assign w_sample = r_sync[SYNC_STAGES-1] ^ INVERT;
   // r_prev resets to all ones, a count no window can reach, so the first capture is never stable
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_sync <= '0;
         r_win  <= '0;
         r_cnt  <= '0;
         r_prev <= '1;
         r_done <= 1'b0;
         level  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_win  <= r_win + 1'b1;
         r_cnt  <= (r_win == '0) ? {{WIDTH{1'b0}}, w_sample} : r_cnt + {{WIDTH{1'b0}}, w_sample};
         r_done <= &r_win;
         valid  <= r_done;
         if (r_done) begin
            level  <= r_cnt[WIDTH] ? '1 : r_cnt[WIDTH-1:0];
            full   <= r_cnt[WIDTH];
            stable <= (r_cnt == r_prev);
            r_prev <= r_cnt;
         end
      end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: window-sum model of the decoder checked every cycle on a
// normal and an inverting instance sharing one PWM source.
module tb_pwm_decoder;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       pwm = 1'b0;
   logic [7:0] l0, l1;
   logic       v0, v1, f0, f1, s0, s1;

   pwm_decoder #(.WIDTH(8), .INVERT(1'b0), .SYNC_STAGES(2)) u0 (
      .clk(clk), .reset_n(reset_n), .pwm_in(pwm), .level(l0), .valid(v0), .full(f0), .stable(s0));
   pwm_decoder #(.WIDTH(8), .INVERT(1'b1), .SYNC_STAGES(2)) u1 (
      .clk(clk), .reset_n(reset_n), .pwm_in(pwm), .level(l1), .valid(v1), .full(f1), .stable(s1));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // source: team PWM generator (period 256, high while phase < level) or a constant
   logic [7:0] gph = 8'd37;
   int         glvl = 0;
   logic       cst_en = 1'b1;
   logic       cst = 1'b0;
   always begin
      @(posedge clk);
      #3;
      gph++;
      pwm = cst_en ? cst : (int'(gph) < glvl);
   end

   // model: each capture is the plain sum of the input seen two edges earlier over its window
   bit hist [0:16383];
   int e = 0;
   int prev [0:1] = '{-1, -1};
   int ev [0:1] = '{0, 0};
   int el [0:1] = '{0, 0};
   int ef [0:1] = '{0, 0};
   int es [0:1] = '{0, 0};
   always begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         e = 0;
         for (int d = 0; d < 2; d++) begin
            prev[d] = -1; ev[d] = 0; el[d] = 0; ef[d] = 0; es[d] = 0;
         end
      end else begin
         e++;
         if (e < 16384) hist[e] = pwm;
         for (int d = 0; d < 2; d++) ev[d] = 0;
         if (e >= 257 && (e - 257) % 256 == 0 && e < 16384) begin
            for (int d = 0; d < 2; d++) begin
               int sum;
               sum = 0;
               for (int k = 1; k <= 256; k++) begin
                  int idx;
                  idx = e - 257 + k;
                  sum += int'(((idx - 2 >= 1) ? hist[idx-2] : 1'b0) ^ d[0]);
               end
               ev[d] = 1;
               el[d] = (sum > 255) ? 255 : sum;
               ef[d] = int'(sum == 256);
               es[d] = int'(sum == prev[d]);
               prev[d] = sum;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("u0.valid", int'(v0), ev[0]);
      chk("u0.level", int'(l0), el[0]);
      chk("u0.full", int'(f0), ef[0]);
      chk("u0.stable", int'(s0), es[0]);
      chk("u1.valid", int'(v1), ev[1]);
      chk("u1.level", int'(l1), el[1]);
      chk("u1.full", int'(f1), ef[1]);
      chk("u1.stable", int'(s1), es[1]);
   end

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = v0;
      end
      if (!ok) chk("valid_timeout", 0, 1);
   endtask

   initial begin
      int n, cnt, last;
      bit pv;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.level", int'(l0), 0);
      chk("rst.valid", int'(v0), 0);
      chk("rst.prev_marker_ok", int'(s1), 0);
      #2 reset_n = 1'b1;
      // held 0
      wait_valid();
      chk("lo.v1.stable", int'(s0), 0);
      wait_valid();
      chk("lo.level", int'(l0), 0);
      chk("lo.full", int'(f0), 0);
      chk("lo.stable", int'(s0), 1);
      chk("lo.inv.level", int'(l1), 255);
      chk("lo.inv.full", int'(f1), 1);
      // held 1
      cst = 1'b1;
      repeat (3) wait_valid();
      chk("hi.level", int'(l0), 255);
      chk("hi.full", int'(f0), 1);
      chk("hi.stable", int'(s0), 1);
      chk("hi.inv.level", int'(l1), 0);
      chk("hi.inv.full", int'(f1), 0);
      // generator 64
      cst_en = 1'b0;
      glvl = 64;
      repeat (3) wait_valid();
      chk("g64.level", int'(l0), 64);
      chk("g64.full", int'(f0), 0);
      chk("g64.stable", int'(s0), 1);
      chk("g64.inv.level", int'(l1), 192);
      // generator 255
      glvl = 255;
      repeat (3) wait_valid();
      chk("g255.level", int'(l0), 255);
      chk("g255.full", int'(f0), 0);
      chk("g255.inv.level", int'(l1), 1);
      // switch 64 -> 200 mid-window
      glvl = 64;
      repeat (3) wait_valid();
      repeat (128) @(posedge clk);
      glvl = 200;
      wait_valid();
      wait_valid();
      chk("sw.v2.level", int'(l0), 200);
      chk("sw.v2.stable", int'(s0), 0);
      wait_valid();
      chk("sw.v3.level", int'(l0), 200);
      chk("sw.v3.stable", int'(s0), 1);
      chk("sw.v3.inv.level", int'(l1), 56);
      // reset mid-window
      glvl = 64;
      repeat (3) wait_valid();
      n = 0;
      while (e % 256 != 100 && n < 600) begin
         @(posedge clk);
         n++;
      end
      #3 reset_n = 1'b0;
      #1;
      chk("arst.level", int'(l0), 0);
      chk("arst.stable", int'(s0), 0);
      chk("arst.inv.level", int'(l1), 0);
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;
      n = 0;
      pv = 1'b0;
      while (!pv && n < 600) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
         pv = v0;
      end
      chk("arst.first_valid_edges", n, 257);
      chk("arst.first_stable", int'(s0), 0);
      // pulse count over 10 windows
      cnt = 0;
      last = -1;
      pv = 1'b0;
      for (int i = 0; i < 2560; i++) begin
         @(negedge clk);
         #1;
         if (v0) begin
            cnt++;
            if (pv) chk("pulse.width", 2, 1);
            if (last >= 0) chk("pulse.gap", i - last, 256);
            last = i;
         end
         pv = v0;
      end
      chk("pulse.count", cnt, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
